// File: rtl/fp_enc_pkg.sv
// Shared widths, rounding-mode encodings and helpers for the linear-to-float encoder.
package fp_enc_pkg;

  localparam int EXP_W_DEF = 3;
  localparam int MAN_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  function automatic int e_max_f(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int mag_w_f(input int exp_w, input int man_w);
    return man_w + e_max_f(exp_w);
  endfunction

  function automatic int in_w_f(input int exp_w, input int man_w);
    return mag_w_f(exp_w, man_w) + 1;
  endfunction

  function automatic logic [2:0] lzc4(input logic [3:0] x);
    casez (x)
      4'b1???: return 3'd0;
      4'b01??: return 3'd1;
      4'b001?: return 3'd2;
      4'b0001: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Recursive leading-zero counter; halves the word until 4-bit-or-narrower leaves remain.
module fp_lzc
  import fp_enc_pkg::*;
#(
  parameter  int W  = 11,
  localparam int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  output logic [OW-1:0] lz
);

  generate
    if (W <= 4) begin : g_leaf
      logic [3:0] xp;
      // Pad below with ones so a narrow leaf never counts past W.
      always_comb begin
        xp = '1;
        xp[3 -: W] = x;
      end
      assign lz = OW'(lzc4(xp));
    end else begin : g_split
      localparam int WL  = W / 2;
      localparam int WH  = W - WL;
      localparam int OWH = $clog2(WH + 1);
      localparam int OWL = $clog2(WL + 1);
      logic [OWH-1:0] lz_hi;
      logic [OWL-1:0] lz_lo;

      fp_lzc #(.W(WH)) u_hi (.x(x[W-1:WL]), .lz(lz_hi));
      fp_lzc #(.W(WL)) u_lo (.x(x[WL-1:0]), .lz(lz_lo));

      assign lz = (lz_hi == OWH'(WH)) ? OW'(WH + int'(lz_lo)) : OW'(lz_hi);
    end
  endgenerate

endmodule

// File: rtl/fp_encode_pipe.sv
// Three-stage signed linear-to-float encoder with valid/ready flow control.
// in_ready is combinational from out_ready: the whole pipe advances or holds as one.
module fp_encode_pipe
  import fp_enc_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int E_MAX = e_max_f(EXP_W),
  localparam int MAG_W = mag_w_f(EXP_W, MAN_W),
  localparam int IN_W  = in_w_f(EXP_W, MAN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_m,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int STAGES = 3;
  localparam int LZ_W   = $clog2(MAG_W + 1);

  typedef struct packed {
    logic             s;
    logic             presat;
    logic             rnd;
    logic [MAG_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic             s;
    logic             presat;
    logic             rnd;
    logic             rbit;
    logic [EXP_W-1:0] e0;
    logic [MAN_W-1:0] m;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            adv;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S1: magnitude. The most negative code has no positive twin, so clamp and flag it.
  logic is_min;
  assign is_min = (in_data == {1'b1, {MAG_W{1'b0}}});

  always_comb begin
    s1_d        = '0;
    s1_d.s      = in_data[IN_W-1];
    s1_d.presat = is_min;
    s1_d.rnd    = rnd_mode;
    if (is_min)             s1_d.mag = '1;
    else if (in_data[IN_W-1]) s1_d.mag = ~in_data[MAG_W-1:0] + MAG_W'(1);
    else                    s1_d.mag = in_data[MAG_W-1:0];
  end

  // S2: normalise. Shifting {mag,0} puts the round bit at [0] and the mantissa above it.
  logic [LZ_W-1:0]  lz;
  int               lz_cap;
  logic [EXP_W-1:0] e0;
  logic [MAN_W:0]   sh;

  fp_lzc #(.W(MAG_W)) u_lzc (.x(s1_q.mag), .lz(lz));

  assign lz_cap = (int'(lz) < E_MAX) ? int'(lz) : E_MAX;
  assign e0     = EXP_W'(E_MAX - lz_cap);
  assign sh     = (MAN_W+1)'({s1_q.mag, 1'b0} >> e0);

  always_comb begin
    s2_d        = '0;
    s2_d.s      = s1_q.s;
    s2_d.presat = s1_q.presat;
    s2_d.rnd    = s1_q.rnd;
    s2_d.rbit   = sh[0];
    s2_d.e0     = e0;
    s2_d.m      = sh[MAN_W:1];
  end

  // S3: round, renormalise on mantissa carry, clamp on exponent overflow.
  logic [MAN_W:0]   m_inc;
  logic [EXP_W-1:0] e3;
  logic [MAN_W-1:0] m3;
  logic             sat3;

  assign m_inc = {1'b0, s2_q.m} + (MAN_W+1)'(s2_q.rnd == RND_HALF_UP && s2_q.rbit);

  always_comb begin
    e3   = s2_q.e0;
    m3   = m_inc[MAN_W-1:0];
    sat3 = s2_q.presat;
    if (m_inc[MAN_W]) begin
      if (s2_q.e0 == EXP_W'(E_MAX)) begin
        e3   = '1;
        m3   = '1;
        sat3 = 1'b1;
      end else begin
        e3          = s2_q.e0 + EXP_W'(1);
        m3          = '0;
        m3[MAN_W-1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      out_s   <= 1'b0;
      out_e   <= '0;
      out_m   <= '0;
      out_sat <= 1'b0;
    end else if (adv) begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      out_s   <= s2_q.s;
      out_e   <= e3;
      out_m   <= m3;
      out_sat <= sat3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && (sat_cnt != '1))
      sat_cnt <= sat_cnt + CNT_W'(1);
  end

endmodule

// File: doc/fp_encode_pipe.md
Name: fp_encode_pipe

Overview:
- Pipelined, parametrised linear-to-float encoder: signed two's-complement sample in, packed {sign, exponent, mantissa} out.
- Generalises the fixed 12-bit combinational exponent/mantissa path of the Lab2 converter:
  - parametrised exponent and mantissa widths;
  - run-time selectable rounding mode;
  - valid/ready handshaking with backpressure;
  - a saturation event counter.
- Sits between the sample source and the display/serial formatter.

Parameters:
- EXP_W, 3, exponent width. E_MAX = 2^EXP_W - 1.
- MAN_W, 4, mantissa width. Stored mantissa includes the leading one; no hidden bit.
- CNT_W, 8, width of the saturation counter.
- Derived localparams, not overridable:
  - MAG_W = MAN_W + E_MAX (11 by default);
  - IN_W = MAG_W + 1 (12 by default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  IN_W  signed two's-complement sample.
- rnd_mode  in  1  0 = truncate, 1 = round-half-up. Sampled with in_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_s  out  1  sign.
- out_e  out  EXP_W  exponent.
- out_m  out  MAN_W  mantissa.
- out_sat  out  1  result was clamped to max magnitude.
- sat_cnt  out  CNT_W  count of accepted saturated outputs.

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_* and sat_cnt go to 0. In-flight samples are discarded. in_ready reads 1 once out_valid = 0.
- Pipeline has three register stages (S1, S2, S3); S3 drives the out_* ports.
  - Global advance: adv = !out_valid | out_ready.
  - in_ready = adv. This is a combinational path from out_ready; it is intentional and documented.
  - A sample is accepted when in_valid & in_ready.
  - Latency: accepted in cycle N gives out_valid in cycle N+3 when there is no backpressure. Throughput is 1 sample/cycle.
  - While adv = 0, all stages hold. Bubbles are not collapsed.
- S1: register sign = in_data[IN_W-1]; register mag = |in_data| on MAG_W bits.
  - in_data = -2^(IN_W-1) maps to mag = 2^MAG_W - 1 with a pre-sat flag set.
  - rnd_mode is carried with the sample.
- S2: lz = leading-zero count of mag (0..MAG_W); E0 = E_MAX - min(lz, E_MAX).
  - E0 = 0: M = mag[MAN_W-1:0], rbit = 0.
  - Otherwise: M = mag[E0+MAN_W-1 : E0], rbit = mag[E0-1].
- S3 rounding:
  - If rnd_mode & rbit, then M' = M + 1.
  - If M' = 2^MAN_W: M = 2^(MAN_W-1) and E = E0 + 1.
  - If that E would exceed E_MAX: E = E_MAX, M = all ones, sat = 1.
  - sat is also set by the S1 pre-sat flag.
- Sign handling:
  - Zero input encodes as S=0, E=0, M=0.
  - Negative inputs keep S=1 even if the magnitude rounds.
- sat_cnt increments on each out_valid & out_ready & out_sat. It saturates at all-ones and does not wrap.
- rnd_mode changing mid-stream affects only samples accepted after the change.

Decomposition:
- Shared package/include fp_enc_pkg:
  - EXP_W/MAN_W defaults;
  - MAG_W/IN_W/E_MAX derivation functions;
  - rounding-mode encodings (RND_TRUNC = 0, RND_HALF_UP = 1).
- One sub-module, fp_lzc: parameterised leading-zero counter over W bits.
  - Output width clog2(W+1).
  - All-zero input returns W.
  - Built as a recursive or tree split of 4-bit LZC leaves.

Test Plan:
- Value check, rnd_mode = 1:
  - 422 -> S0 E5 M1101 sat0
  - 46 -> S0 E2 M1100
  - same 46 with rnd_mode = 0 -> M1011
- Carry renormalise: 63, round -> S0 E3 M1000 sat0.
- Saturation:
  - 2047, round -> S0 E7 M1111 sat1
  - -2048 -> S1 E7 M1111 sat1
  - sat_cnt = 2 after both are accepted
- Small and zero values:
  - -5 -> S1 E0 M0101
  - 0 -> S0 E0 M0000
  - 1 -> S0 E0 M0001
- Handshake:
  - Stream 8 samples back-to-back with out_ready = 1 -> outputs appear 3 cycles after acceptance, in order.
  - Drop out_ready for 4 cycles mid-stream -> in_ready = 0, outputs held stable, no loss or duplication.
- Reset and parameters:
  - Assert rst_n low mid-stream -> outputs, valids and sat_cnt read 0 immediately; post-release output begins only with new samples.
  - Repeat the value checks with EXP_W = 2, MAN_W = 5 (IN_W = 9) against a reference model; exhaustive sweep over all inputs.
